// File: rtl/uart_rx_fifo_writer.sv
// 8N1 UART receiver with 16x oversampling; each good byte becomes a single-cycle FIFO write.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking (PARITY state, parityErr output).
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rxs
// START  | validating the start bit at its midpoint
// DATA   | sampling 8 data bits, LSB first
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit; write, overflow or framing error
// BREAK  | line held low after a framing error, waiting for idle
module uart_rx_fifo_writer #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_COUNT = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxData,
  input  logic       full,
  output logic       wrEn,
  output logic [7:0] din,
  output logic       frameErr,
  output logic       overflow,
  output logic       parityErr,
  output logic       busy
);

  localparam int TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_COUNT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} stateT;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} stateT;
`endif

  stateT state, nextState;

  logic          rxMeta, rxs;
  logic [TW-1:0] tickCnt;
  logic          tick;
  logic [3:0]    sampleCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          midSample;
  logic          startFrame, startData, shiftEn;
  logic          doWrite, doOverflow, doFrameErr, doParityErr;
`ifdef UART_RX_PARITY_EN
  logic          parLatch, parMismatch;
`endif

  assign tick      = (tickCnt == TICK_LAST);
  assign midSample = tick && (sampleCnt == 4'd15);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      rxMeta <= rxData;
      rxs    <= rxMeta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState   = state;
    startFrame  = 1'b0;
    startData   = 1'b0;
    shiftEn     = 1'b0;
    doWrite     = 1'b0;
    doOverflow  = 1'b0;
    doFrameErr  = 1'b0;
    doParityErr = 1'b0;
`ifdef UART_RX_PARITY_EN
    parLatch    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxs) begin
          nextState  = START;
          startFrame = 1'b1;
        end
      end
      // the tick that moves the sample count from 6 to 7 is mid start bit
      START: begin
        if (tick && sampleCnt == 4'd6) begin
          if (!rxs) begin
            nextState = DATA;
            startData = 1'b1;
          end else begin
            nextState = IDLE;
          end
        end
      end
      DATA: begin
        if (midSample) begin
          shiftEn = 1'b1;
          if (bitCnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            nextState = PARITY;
`else
            nextState = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (midSample) begin
          parLatch  = 1'b1;
          nextState = STOP;
        end
      end
`endif
      STOP: begin
        if (midSample) begin
          if (!rxs) begin
            doFrameErr = 1'b1;
`ifdef UART_RX_PARITY_EN
            doParityErr = parMismatch;
`endif
            nextState  = BREAK;
          end else begin
            nextState = IDLE;
`ifdef UART_RX_PARITY_EN
            if (parMismatch) doParityErr = 1'b1;
            else if (full)   doOverflow  = 1'b1;
            else             doWrite     = 1'b1;
`else
            if (full) doOverflow = 1'b1;
            else      doWrite    = 1'b1;
`endif
          end
        end
      end
      BREAK: begin
        if (rxs) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tickCnt   <= '0;
      sampleCnt <= 4'd0;
      bitCnt    <= 3'd0;
      shiftReg  <= 8'd0;
    end else begin
      if (startFrame || tick) tickCnt <= '0;
      else                    tickCnt <= tickCnt + 1'b1;
      if (startFrame || startData) sampleCnt <= 4'd0;
      else if (tick)               sampleCnt <= sampleCnt + 4'd1;
      if (startData)    bitCnt <= 3'd0;
      else if (shiftEn) bitCnt <= bitCnt + 3'd1;
      if (shiftEn) shiftReg <= {rxs, shiftReg[7:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrEn     <= 1'b0;
      din      <= 8'd0;
      frameErr <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wrEn     <= doWrite;
      frameErr <= doFrameErr;
      overflow <= doOverflow;
      if (doWrite) din <= shiftReg;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parMismatch <= 1'b0;
      parityErr   <= 1'b0;
    end else begin
      if (parLatch) parMismatch <= rxs ^ (^shiftReg);
      parityErr <= doParityErr;
    end
  end
`else
  assign parityErr = doParityErr;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Self-checking bench for uart_rx_fifo_writer: directed frames plus random frames against a frame-level model.
module tb_uart_rx_fifo_writer;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxData = 1'b1;
  logic       full = 1'b0;
  logic       wrEn, frameErr, overflow, parityErr, busy;
  logic [7:0] din;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int startCyc = 0;
  int lastWrCyc = 0;

  logic [7:0] expQ[$];
  logic [7:0] obsQ[$];
  int expFrame = 0, expOvf = 0, expPar = 0;
  int obsFrame = 0, obsOvf = 0, obsPar = 0;

  uart_rx_fifo_writer #(
    .CLK_FREQ (16_000_000),
    .BAUD_RATE(1_000_000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxData   (rxData),
    .full     (full),
    .wrEn     (wrEn),
    .din      (din),
    .frameErr (frameErr),
    .overflow (overflow),
    .parityErr(parityErr),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: collects what the DUT wrote/flagged and checks per-cycle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (wrEn) begin
        obsQ.push_back(din);
        lastWrCyc = cyc;
        checkEq("wrEnWhileFull", full, 0);
      end
      if (frameErr)  obsFrame++;
      if (overflow)  obsOvf++;
      if (parityErr) obsPar++;
      if (wrEn || overflow || frameErr)
        checkEq("exclusivePulse", $countones({wrEn, overflow, frameErr}), 1);
    end
  end

  // Frame-level model: what one frame should produce given the line contents and full.
  task automatic modelFrame(input logic [7:0] b, input logic stopBit, input logic parBit);
    logic parBad;
    parBad = PAR_ON && ((^b) ^ parBit);
    if (parBad) expPar++;
    if (!stopBit)       expFrame++;
    else if (parBad)    ;
    else if (full)      expOvf++;
    else                expQ.push_back(b);
  endtask

  task automatic sendBits(input logic v, input int n);
    rxData = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit, input logic parBit);
    modelFrame(b, stopBit, parBit);
    startCyc = cyc;
    sendBits(1'b0, 16);
    for (int i = 0; i < 8; i++) sendBits(b[i], 16);
    if (PAR_ON) sendBits(parBit, 16);
    sendBits(stopBit, 16);
    rxData = 1'b1;
  endtask

  task automatic compareAll();
    checkEq("writeCount", obsQ.size(), expQ.size());
    while (obsQ.size() > 0 && expQ.size() > 0)
      checkEq("dinValue", obsQ.pop_front(), expQ.pop_front());
    obsQ.delete();
    expQ.delete();
    checkEq("frameErrCount", obsFrame, expFrame);
    checkEq("overflowCount", obsOvf, expOvf);
    checkEq("parityErrCount", obsPar, expPar);
  endtask

  task automatic checkAllZero(input string tag);
    checkEq({tag, "_wrEn"}, wrEn, 0);
    checkEq({tag, "_din"}, din, 0);
    checkEq({tag, "_frameErr"}, frameErr, 0);
    checkEq({tag, "_overflow"}, overflow, 0);
    checkEq({tag, "_parityErr"}, parityErr, 0);
    checkEq({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [7:0] b;
    logic       stopBit, parBit;
    int         lat;
    bit         dropped;

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    sendBits(1'b1, 10);

    // single byte, latency about 9.5 bits after the start edge
    sendFrame(8'hA5, 1'b1, ^8'hA5);
    sendBits(1'b1, 8);
    lat = lastWrCyc - startCyc;
    checkEq("latencyInWindow", (lat >= 148 && lat <= 160), 1);
    compareAll();

    // back-to-back frames, zero idle time
    sendFrame(8'h00, 1'b1, ^8'h00);
    sendFrame(8'hFF, 1'b1, ^8'hFF);
    sendFrame(8'h3C, 1'b1, ^8'h3C);
    sendBits(1'b1, 8);
    compareAll();

    // 4-clk glitch is rejected at the start-bit midpoint
    sendBits(1'b0, 4);
    checkEq("glitchBusyHigh", busy, 1);
    rxData = 1'b1;
    dropped = 1'b0;
    for (int i = 0; i < 10 && !dropped; i++) begin
      @(negedge clk);
      if (!busy) dropped = 1'b1;
    end
    checkEq("glitchBusyDrop", busy, 0);
    sendBits(1'b1, 20);
    compareAll();

    // framing error followed by a held-low line, then a good byte
    sendFrame(8'h55, 1'b0, ^8'h55);
    sendBits(1'b0, 40);
    checkEq("breakBusy", busy, 1);
    sendBits(1'b1, 30);
    sendFrame(8'h12, 1'b1, ^8'h12);
    sendBits(1'b1, 8);
    compareAll();

    // overflow while full, then normal write after release
    full = 1'b1;
    sendFrame(8'h77, 1'b1, ^8'h77);
    sendBits(1'b1, 8);
    full = 1'b0;
    sendFrame(8'h78, 1'b1, ^8'h78);
    sendBits(1'b1, 8);
    compareAll();

    // reset during bit 4 of 0x99 discards the partial frame
    b = 8'h99;
    sendBits(1'b0, 16);
    for (int i = 0; i < 4; i++) sendBits(b[i], 16);
    sendBits(b[4], 5);
    rxData = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkAllZero("midReset");
    rst = 1'b0;
    sendBits(1'b1, 30);
    sendFrame(8'h42, 1'b1, ^8'h42);
    sendBits(1'b1, 8);
    compareAll();

    if (PAR_ON) begin
      sendFrame(8'h03, 1'b1, 1'b1);
      sendBits(1'b1, 8);
      sendFrame(8'h03, 1'b1, 1'b0);
      sendBits(1'b1, 8);
      compareAll();
    end

    // random frames: data, full, stop errors, parity errors, gaps
    for (int n = 0; n < 40; n++) begin
      b       = 8'($urandom);
      stopBit = ($urandom_range(0, 5) != 0);
      parBit  = (^b) ^ ($urandom_range(0, 5) == 0);
      full    = ($urandom_range(0, 3) == 0);
      sendFrame(b, stopBit, parBit);
      if (!stopBit) begin
        sendBits(1'b0, $urandom_range(0, 40));
        sendBits(1'b1, $urandom_range(4, 20));
      end else begin
        sendBits(1'b1, $urandom_range(0, 12));
      end
      full = 1'b0;
    end
    sendBits(1'b1, 20);
    compareAll();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
